// File: rtl/syn_fifo_if.sv
// Handshake and status bundle for syn_fifo.
// The master drives write/read requests; the slave (the FIFO) returns data and status.
interface syn_fifo_if #(
    parameter int WIDTH_FIFO = 8,
    parameter int DEPTH_FIFO = 16
);
    localparam int CW = $clog2(DEPTH_FIFO) + 1;

    logic                  wen;
    logic [WIDTH_FIFO-1:0] wdata;
    logic                  ren;
    logic [WIDTH_FIFO-1:0] rdata;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wen, wdata, ren,
        input  rdata, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wen, wdata, ren,
        output rdata, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/syn_fifo.sv
// Single-clock FIFO with registered status flags, sticky overflow/underflow,
// and either registered-read (FWFT=0) or first-word-fall-through (FWFT=1) output.
module syn_fifo #(
    parameter int WIDTH_FIFO = 8,
    parameter int DEPTH_FIFO = 16,
    parameter int AFULL_TH   = 14,
    parameter int AEMPTY_TH  = 2,
    parameter int FWFT       = 0
) (
    input logic        clk,
    input logic        rst,
    syn_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_FIFO);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0]         ptr_t;
    typedef logic [CW-1:0]         cnt_t;
    typedef logic [WIDTH_FIFO-1:0] word_t;

    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cnt_t CNT_FULL  = cnt_t'(DEPTH_FIFO);
    localparam cnt_t CNT_AFULL = cnt_t'(AFULL_TH);
    localparam cnt_t CNT_AEMPT = cnt_t'(AEMPTY_TH);

    word_t mem_q [DEPTH_FIFO];

    ptr_t  wr_ptr_q, wr_ptr_d;
    ptr_t  rd_ptr_q, rd_ptr_d;
    cnt_t  count_q, count_d;
    word_t rdata_q, rdata_d;
    logic  empty_q, empty_d;
    logic  full_q, full_d;
    logic  afull_q, afull_d;
    logic  aempty_q, aempty_d;
    logic  ovf_q, ovf_d;
    logic  udf_q, udf_d;

    logic  wr_acc;
    logic  rd_acc;

    always_comb begin
        wr_acc   = bus.wen && !full_q;
        rd_acc   = bus.ren && !empty_q;

        wr_ptr_d = wr_acc ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;

        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        empty_d  = (count_d == '0);
        full_d   = (count_d == CNT_FULL);
        afull_d  = (count_d >= CNT_AFULL);
        aempty_d = (count_d <= CNT_AEMPT);

        ovf_d    = ovf_q | (bus.wen & full_q);
        udf_d    = udf_q | (bus.ren & empty_q);

        rdata_d  = rdata_q;
        if (FWFT == 0) begin
            if (rd_acc) rdata_d = mem_q[rd_ptr_q];
        end else if (count_d != '0) begin
            // The next head can be the word written this very edge (empty, or one word
            // being read while a new one arrives); memory does not hold it yet.
            if (wr_acc && (wr_ptr_q == rd_ptr_d)) rdata_d = bus.wdata;
            else                                  rdata_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem_q[wr_ptr_q] <= bus.wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign bus.rdata        = rdata_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: doc/syn_fifo.md
SYN_FIFO -- requirements
Module: syn_fifo

Interface
REQ-001 Parameter WIDTH_FIFO, default 8: data width in bits, >= 1.
REQ-002 Parameter DEPTH_FIFO, default 16: storage words; power of two, >= 2.
REQ-003 Parameter AFULL_TH, default 14: almost_full threshold, 1..DEPTH_FIFO.
REQ-004 Parameter AEMPTY_TH, default 2: almost_empty threshold, 0..DEPTH_FIFO-1.
REQ-005 Parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-006 Port clk  input  1: single clock; all state updates on rising edge.
REQ-007 Port rst  input  1: reset, synchronous, active-high.
REQ-008 Port wen  input  1: write request.
REQ-009 Port wdata  input  WIDTH_FIFO: write data, sampled with an accepted write.
REQ-010 Port ren  input  1: read request.
REQ-011 Port rdata  output  WIDTH_FIFO: read data.
REQ-012 Port empty  output  1: high when count == 0.
REQ-013 Port full  output  1: high when count == DEPTH_FIFO.
REQ-014 Port almost_full  output  1: high when count >= AFULL_TH.
REQ-015 Port almost_empty  output  1: high when count <= AEMPTY_TH.
REQ-016 Port count  output  log2(DEPTH_FIFO)+1: words currently stored.
REQ-017 Port overflow  output  1: sticky, write attempted while full.
REQ-018 Port underflow  output  1: sticky, read attempted while empty.

Function
REQ-019 Write accepted iff wen && !full at a rising edge; wdata stored at write pointer; write pointer increments modulo DEPTH_FIFO.
REQ-020 Read accepted iff ren && !empty at a rising edge; read pointer increments modulo DEPTH_FIFO.
REQ-021 count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write+read or no accepted op; updates at the same edge.
REQ-022 empty, full, almost_full, almost_empty: registered, derived from next count value; valid in the cycle after the edge that changes count.
REQ-023 Simultaneous wen+ren when empty: read rejected, underflow set, write accepted, count -> 1.
REQ-024 Simultaneous wen+ren when full: write rejected, overflow set, read accepted, count -> DEPTH_FIFO-1.
REQ-025 Simultaneous wen+ren with 0 < count < DEPTH_FIFO: both accepted; count unchanged.
REQ-026 Rejected operations do not alter memory, pointers, count or rdata.
REQ-027 FWFT=0: on an accepted read, rdata loads the head word at that edge (1-cycle latency); rdata holds between reads.
REQ-028 FWFT=1: whenever !empty, rdata presents the head word with no ren required; an accepted read advances rdata to the next word at the same edge; rdata undefined-but-stable (holds last value) while empty.
REQ-029 FWFT=1: first write to an empty FIFO makes rdata valid and empty low in the cycle after the write edge.
REQ-030 Pointers wrap from DEPTH_FIFO-1 to 0 with no data loss or duplication.
REQ-031 overflow and underflow, once set, remain high until reset.

Reset
REQ-032 rst sampled high at a rising edge: pointers = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, rdata = 0.
REQ-033 Reset has priority over wen/ren in the same cycle; memory contents are not cleared.
REQ-034 Reset mid-operation discards all stored words; first accepted write after reset lands at address 0.

Verification (WIDTH_FIFO=8, DEPTH_FIFO=16, AFULL_TH=14, AEMPTY_TH=2)
REQ-035 FWFT=0: write 0x03..0x0A, then 8 reads -> rdata 0x03..0x0A in order, each 1 cycle after its read edge; empty=1 after last read.
REQ-036 Fill 16 words -> full=1, count=16, almost_full from count 14; 17th write -> overflow=1, count stays 16, data intact on readback.
REQ-037 Read when empty after reset -> underflow=1, count=0, rdata=0; underflow stays 1 until rst.
REQ-038 Write/read 40 words with count held at 5 (simultaneous wen+ren) -> pointers wrap twice, readback sequence exact, count constant 5.
REQ-039 FWFT=1: single write 0x5A to empty -> next cycle empty=0, rdata=0x5A with ren low; one read -> empty=1.
REQ-040 Write 6 words, assert rst with wen high -> count=0, empty=1, flags cleared; next write 0x11 read back as 0x11.
